// File: rtl/line_fill_ctrl.sv
// Single-line read buffer in front of a 64-bit burst memory: answers hits in one
// cycle and refills the whole 256-bit line with a 4-beat burst on a miss.
module line_fill_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ufp_addr,
    input  logic [3:0]  ufp_rmask,
    input  logic        flush,
    output logic [31:0] ufp_rdata,
    output logic        ufp_resp,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    input  logic        bmem_ready,
    input  logic [63:0] bmem_rdata,
    input  logic        bmem_rvalid
);

    typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

    state_t       state, state_next;
    logic [255:0] line_data;
    logic [26:0]  tag;
    logic         valid;
    logic [1:0]   beat_cnt;
    logic         kill;
    logic [31:0]  addr_reg;
    logic         hit_pend;
    logic [2:0]   hit_word;
    logic         req;
    logic         hit;
    logic         resp_live;
    logic [2:0]   resp_word;
    logic         unused_addr_bits;

    assign req = |ufp_rmask;
    assign hit = (state == IDLE) && req && valid && (tag == ufp_addr[31:5]);
    assign unused_addr_bits = ^{ufp_addr[1:0], addr_reg[1:0]};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req && !hit) state_next = REQ;
            REQ:     if (bmem_ready) state_next = FILL;
            FILL:    if (bmem_rvalid && beat_cnt == 2'd3) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid    <= 1'b0;
            tag      <= '0;
            beat_cnt <= '0;
            kill     <= 1'b0;
            addr_reg <= '0;
            hit_pend <= 1'b0;
            hit_word <= '0;
        end else begin
            state    <= state_next;
            hit_pend <= hit;
            if (hit) hit_word <= ufp_addr[4:2];
            case (state)
                IDLE: if (req && !hit) begin
                    addr_reg <= ufp_addr;
                    valid    <= 1'b0;
                    kill     <= 1'b0;
                end
                REQ:  if (flush) kill <= 1'b1;
                FILL: begin
                    if (flush) kill <= 1'b1;
                    if (bmem_rvalid) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3) begin
                            valid <= 1'b1;
                            tag   <= addr_reg[31:5];
                        end
                    end
                end
                RESP: kill <= 1'b0;
                default: ;
            endcase
        end
    end

    // NOTE: the line storage is deliberately not reset; valid guards it after reset.
    always_ff @(posedge clk) begin
        if (state == FILL && bmem_rvalid)
            line_data[{beat_cnt, 6'd0} +: 64] <= bmem_rdata;
    end

    // A flush in the response cycle kills that response; an older kill is held in kill.
    assign resp_live = ((state == RESP) && !kill) || hit_pend;
    assign resp_word = (state == RESP) ? addr_reg[4:2] : hit_word;
    assign ufp_resp  = resp_live && !flush;
    assign ufp_rdata = ufp_resp ? line_data[{resp_word, 5'd0} +: 32] : '0;

    assign bmem_read = (state == REQ);
    assign bmem_addr = bmem_read ? {addr_reg[31:5], 5'd0} : '0;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Self-checking bench for line_fill_ctrl: directed scenarios plus randomized
// traffic checked against a one-line cache model and a synthetic memory image.
module tb_line_fill_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] ufp_addr;
    logic [3:0]  ufp_rmask;
    logic        flush;
    logic [31:0] ufp_rdata;
    logic        ufp_resp;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_ready;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    int errors = 0;
    int checks = 0;

    logic        obs_resp;
    logic [31:0] obs_rdata;
    logic        obs_bread;
    logic [31:0] obs_baddr;

    // Model of the buffer: which line (if any) is held
    logic        model_valid;
    logic [31:0] model_line;

    line_fill_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ufp_addr    (ufp_addr),
        .ufp_rmask   (ufp_rmask),
        .flush       (flush),
        .ufp_rdata   (ufp_rdata),
        .ufp_resp    (ufp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: line 0x1000 carries the 0x11../0x22../0x33../0x44.. pattern
    function automatic logic [63:0] mem_beat(input logic [31:0] line, input logic [1:0] k);
        logic [63:0] r;
        if (line == 32'h0000_1000)
            r = 64'h1111_1111_1111_1111 * (64'(k) + 64'd1);
        else
            r = {line ^ 32'hC0DE_0000 ^ 32'(k), line + 32'(k) * 32'h0101_0101 + 32'h5A};
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] addr);
        logic [63:0] b;
        b = mem_beat({addr[31:5], 5'd0}, addr[4:3]);
        return addr[2] ? b[63:32] : b[31:0];
    endfunction

    function automatic logic model_hit(input logic [31:0] addr);
        return model_valid && (model_line == {addr[31:5], 5'd0});
    endfunction

    task automatic run_cycle(input logic [3:0] rm, input logic [31:0] a, input logic fl,
                             input logic rdy, input logic rv, input logic [63:0] rd);
        ufp_rmask   = rm;
        ufp_addr    = a;
        flush       = fl;
        bmem_ready  = rdy;
        bmem_rvalid = rv;
        bmem_rdata  = rd;
        @(negedge clk);
        obs_resp  = ufp_resp;
        obs_rdata = ufp_rdata;
        obs_bread = bmem_read;
        obs_baddr = bmem_addr;
        @(posedge clk);
        #1;
        ufp_rmask   = '0;
        flush       = 1'b0;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
    endtask

    // flush_mode: 0 none, 1 in REQ, 2 in FILL after first beat, 3 in RESP
    task automatic do_miss(input logic [31:0] addr, input int flush_mode);
        logic [31:0] line;
        int waits;
        int gap;
        line = {addr[31:5], 5'd0};
        run_cycle(4'($urandom_range(1, 15)), addr, 1'b0, 1'b0, 1'b0, 64'd0);
        checks++;
        if (obs_resp !== 1'b0 || obs_bread !== 1'b0) begin
            errors++;
            $display("FAIL miss_accept addr=%h resp=%b bread=%b required resp=0 bread=0",
                     addr, obs_resp, obs_bread);
        end
        model_valid = 1'b0;
        waits = $urandom_range(0, 3);
        for (int i = 0; i <= waits; i++) begin
            run_cycle(4'($urandom_range(0, 15)), 32'($urandom), (flush_mode == 1) && (i == waits),
                      (i == waits), 1'($urandom), {$urandom, $urandom});
            checks++;
            if (obs_bread !== 1'b1 || obs_baddr !== line || obs_resp !== 1'b0) begin
                errors++;
                $display("FAIL miss_req addr=%h bread=%b baddr=%h resp=%b required bread=1 baddr=%h resp=0",
                         addr, obs_bread, obs_baddr, obs_resp, line);
            end
        end
        for (int k = 0; k < 4; k++) begin
            gap = $urandom_range((flush_mode == 2 && k == 1) ? 1 : 0, 2);
            for (int g = 0; g < gap; g++) begin
                run_cycle(4'($urandom_range(0, 15)), addr, (flush_mode == 2) && (k == 1) && (g == 0),
                          1'($urandom), 1'b0, {$urandom, $urandom});
                checks++;
                if (obs_bread !== 1'b0 || obs_resp !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_gap addr=%h bread=%b resp=%b required 0 0",
                             addr, obs_bread, obs_resp);
                end
            end
            run_cycle(4'($urandom_range(0, 15)), addr, 1'b0, 1'($urandom), 1'b1, mem_beat(line, 2'(k)));
            checks++;
            if (obs_bread !== 1'b0 || obs_resp !== 1'b0 || obs_baddr !== 32'd0) begin
                errors++;
                $display("FAIL fill_beat addr=%h beat=%0d bread=%b resp=%b baddr=%h required 0 0 0",
                         addr, k, obs_bread, obs_resp, obs_baddr);
            end
        end
        // Request in the RESP cycle targets the new line and must be ignored
        run_cycle(4'hF, addr, flush_mode == 3, 1'b0, 1'b1, {$urandom, $urandom});
        checks++;
        if (obs_resp !== (flush_mode == 0) ||
            obs_rdata !== ((flush_mode == 0) ? exp_word(addr) : 32'd0)) begin
            errors++;
            $display("FAIL miss_resp addr=%h mode=%0d resp=%b rdata=%h required resp=%b rdata=%h",
                     addr, flush_mode, obs_resp, obs_rdata, flush_mode == 0,
                     (flush_mode == 0) ? exp_word(addr) : 32'd0);
        end
        model_valid = 1'b1;
        model_line  = line;
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic kill_it);
        run_cycle(4'($urandom_range(1, 15)), addr, 1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom});
        checks++;
        if (obs_resp !== 1'b0 || obs_bread !== 1'b0) begin
            errors++;
            $display("FAIL hit_accept addr=%h resp=%b bread=%b required 0 0", addr, obs_resp, obs_bread);
        end
        run_cycle(4'd0, 32'($urandom), kill_it, 1'b0, 1'b0, 64'd0);
        checks++;
        if (obs_resp !== !kill_it || obs_rdata !== (kill_it ? 32'd0 : exp_word(addr)) || obs_bread !== 1'b0) begin
            errors++;
            $display("FAIL hit_resp addr=%h kill=%b resp=%b rdata=%h bread=%b required resp=%b rdata=%h bread=0",
                     addr, kill_it, obs_resp, obs_rdata, obs_bread, !kill_it,
                     kill_it ? 32'd0 : exp_word(addr));
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        run_cycle(4'hF, 32'h0000_1014, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++;
        if (obs_resp !== 1'b0 || obs_rdata !== 32'd0 || obs_bread !== 1'b0 || obs_baddr !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs resp=%b rdata=%h bread=%b baddr=%h required all zero",
                     obs_resp, obs_rdata, obs_bread, obs_baddr);
        end
        rst_n = 1'b1;
        model_valid = 1'b0;
        model_line  = '0;
        run_cycle(4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        checks++;
        if (obs_resp !== 1'b0 || obs_bread !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle resp=%b bread=%b required 0 0", obs_resp, obs_bread);
        end
    endtask

    task automatic test_cold_miss;
        do_miss(32'h0000_1014, 0);
        checks++;
        if (exp_word(32'h0000_1014) !== 32'h3333_3333) begin
            errors++;
            $display("FAIL cold_miss_image word5=%h required 33333333", exp_word(32'h0000_1014));
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        logic [31:0] want  [3];
        addrs = '{32'h0000_1000, 32'h0000_101C, 32'h0000_1008};
        want  = '{32'h1111_1111, 32'h4444_4444, 32'h2222_2222};
        for (int i = 0; i <= 3; i++) begin
            run_cycle((i < 3) ? 4'hF : 4'h0, (i < 3) ? addrs[i] : 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
            checks++;
            if (obs_resp !== (i > 0) || obs_rdata !== ((i > 0) ? want[i-1] : 32'd0) || obs_bread !== 1'b0) begin
                errors++;
                $display("FAIL hit_stream cycle=%0d resp=%b rdata=%h bread=%b required resp=%b rdata=%h bread=0",
                         i, obs_resp, obs_rdata, obs_bread, i > 0, (i > 0) ? want[i-1] : 32'd0);
            end
        end
    endtask

    task automatic test_conflict;
        do_miss(32'h0000_2000, 0);
        do_miss(32'h0000_1000, 0);
    endtask

    task automatic test_flush_fill;
        do_miss(32'h0000_3008, 2);
        do_hit(32'h0000_3008, 1'b0);
        do_miss(32'h0000_4010, 1);
        do_hit(32'h0000_4014, 1'b0);
        do_miss(32'h0000_3010, 3);
        do_hit(32'h0000_3010, 1'b0);
    endtask

    task automatic test_flush_overlap;
        run_cycle(4'h1, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 64'd0);
        run_cycle(4'h2, 32'h0000_301C, 1'b1, 1'b0, 1'b0, 64'd0);
        checks++;
        if (obs_resp !== 1'b0 || obs_rdata !== 32'd0) begin
            errors++;
            $display("FAIL overlap_killed resp=%b rdata=%h required 0 0", obs_resp, obs_rdata);
        end
        run_cycle(4'h0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd0);
        checks++;
        if (obs_resp !== 1'b1 || obs_rdata !== exp_word(32'h0000_301C)) begin
            errors++;
            $display("FAIL overlap_new resp=%b rdata=%h required 1 %h",
                     obs_resp, obs_rdata, exp_word(32'h0000_301C));
        end
    endtask

    task automatic test_reset_mid_fill;
        logic [31:0] line;
        line = 32'h0000_5000;
        run_cycle(4'hF, 32'h0000_5004, 1'b0, 1'b0, 1'b0, 64'd0);
        run_cycle(4'h0, 32'd0, 1'b0, 1'b1, 1'b0, 64'd0);
        run_cycle(4'h0, 32'd0, 1'b0, 1'b0, 1'b1, mem_beat(line, 2'd0));
        run_cycle(4'h0, 32'd0, 1'b0, 1'b0, 1'b1, mem_beat(line, 2'd1));
        rst_n = 1'b0;
        model_valid = 1'b0;
        run_cycle(4'h0, 32'd0, 1'b0, 1'b0, 1'b1, mem_beat(line, 2'd2));
        checks++;
        if (obs_resp !== 1'b0 || obs_bread !== 1'b0 || obs_rdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_fill_low resp=%b bread=%b rdata=%h required 0 0 0",
                     obs_resp, obs_bread, obs_rdata);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cycle(4'h0, 32'd0, 1'b0, 1'b1, 1'b1, mem_beat(line, 2'd3));
            checks++;
            if (obs_resp !== 1'b0 || obs_bread !== 1'b0) begin
                errors++;
                $display("FAIL rst_fill_after cycle=%0d resp=%b bread=%b required 0 0", i, obs_resp, obs_bread);
            end
        end
        do_miss(32'h0000_5004, 0);
    endtask

    task automatic test_random;
        logic [31:0] addr;
        for (int n = 0; n < 40; n++) begin
            addr = 32'($urandom_range(1, 3)) * 32'h1000 + 32'($urandom_range(0, 31));
            if (model_hit(addr))
                do_hit(addr, ($urandom_range(0, 3) == 0));
            else
                do_miss(addr, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        ufp_addr    = '0;
        ufp_rmask   = '0;
        flush       = 1'b0;
        bmem_ready  = 1'b0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        model_valid = 1'b0;
        model_line  = '0;
        test_reset;
        test_cold_miss;
        test_back_to_back;
        test_conflict;
        test_flush_fill;
        test_flush_overlap;
        test_reset_mid_fill;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
